// File: rtl/mv_job_scheduler.sv
// Round-robin scheduler sharing one matrix-vector engine between two job requesters.
// Optional result watchdog enabled by defining MV_SCHED_TIMEOUT_EN.
module mv_job_scheduler #(
    parameter int D_WIDTH        = 32,
    parameter int M_SIZE         = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [1:0]           s_axis_job_tvalid,
    input  logic [2*D_WIDTH-1:0] s_axis_job_tdata,
    input  logic [1:0]           s_axis_job_tlast,
    output logic [1:0]           s_axis_job_tready,
    output logic                 m_axis_matrix_valid,
    output logic [D_WIDTH-1:0]   m_axis_matrix,
    input  logic                 m_axis_matrix_ready,
    output logic                 m_axis_vector_valid,
    output logic [D_WIDTH-1:0]   m_axis_vector,
    input  logic                 m_axis_vector_ready,
    input  logic                 s_axis_result_valid,
    input  logic [D_WIDTH-1:0]   s_axis_result,
    output logic                 s_axis_result_ready,
    output logic                 m_axis_out_valid,
    output logic [D_WIDTH-1:0]   m_axis_out_data,
    output logic                 m_axis_out_last,
    output logic                 m_axis_out_dest,
    input  logic                 m_axis_out_ready,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int CW = $clog2(M_SIZE*M_SIZE+1);
    localparam logic [CW-1:0] MAT_LAST = CW'(M_SIZE*M_SIZE-1);
    localparam logic [CW-1:0] VEC_LAST = CW'(M_SIZE-1);

    typedef enum logic [2:0] {
        IDLE, ARB, LOAD_MAT, LOAD_VEC, WAIT_RES, DRAIN
    } state_t;

    state_t        state_q;
    logic          gnt_q;
    logic          rr_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

`ifdef MV_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES-1);
    logic [WW-1:0] wd_q;
`endif

    logic               in_valid;
    logic               in_last;
    logic [D_WIDTH-1:0] in_data;
    logic               arb_win;
    logic               mat_fire;
    logic               vec_fire;
    logic               res_fire;

    assign in_valid = s_axis_job_tvalid[gnt_q];
    assign in_last  = s_axis_job_tlast[gnt_q];
    assign in_data  = gnt_q ? s_axis_job_tdata[2*D_WIDTH-1:D_WIDTH]
                            : s_axis_job_tdata[D_WIDTH-1:0];
    assign arb_win  = s_axis_job_tvalid[rr_q] ? rr_q : ~rr_q;

    assign mat_fire = (state_q == LOAD_MAT) && in_valid && m_axis_matrix_ready;
    assign vec_fire = (state_q == LOAD_VEC) && in_valid && m_axis_vector_ready;
    assign res_fire = (state_q == DRAIN) && s_axis_result_valid && m_axis_out_ready;

    assign busy         = (state_q != IDLE);
    assign protocol_err = err_q;

    // Zero-latency pass-through of the granted stream and of the engine results.
    always_comb begin
        s_axis_job_tready   = '0;
        m_axis_matrix_valid = 1'b0;
        m_axis_matrix       = '0;
        m_axis_vector_valid = 1'b0;
        m_axis_vector       = '0;
        s_axis_result_ready = 1'b0;
        m_axis_out_valid    = 1'b0;
        m_axis_out_data     = '0;
        m_axis_out_last     = 1'b0;
        m_axis_out_dest     = 1'b0;
        unique case (state_q)
            LOAD_MAT: begin
                m_axis_matrix_valid      = in_valid;
                m_axis_matrix            = in_data;
                s_axis_job_tready[gnt_q] = m_axis_matrix_ready;
            end
            LOAD_VEC: begin
                m_axis_vector_valid      = in_valid;
                m_axis_vector            = in_data;
                s_axis_job_tready[gnt_q] = m_axis_vector_ready;
            end
            DRAIN: begin
                m_axis_out_valid    = s_axis_result_valid;
                m_axis_out_data     = s_axis_result;
                m_axis_out_last     = (cnt_q == VEC_LAST);
                m_axis_out_dest     = gnt_q;
                s_axis_result_ready = m_axis_out_ready;
            end
            default: ;
        endcase
    end

    // Job sequencing: arbitration, beat counting, tlast checking and result watchdog.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef MV_SCHED_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (|s_axis_job_tvalid) state_q <= ARB;
                end
                ARB: begin
                    gnt_q   <= arb_win;
                    rr_q    <= ~arb_win;
                    cnt_q   <= '0;
                    state_q <= LOAD_MAT;
                end
                LOAD_MAT: begin
                    if (mat_fire) begin
                        if (in_last) err_q <= 1'b1;
                        if (cnt_q == MAT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_VEC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_VEC: begin
                    if (vec_fire) begin
                        if ((cnt_q == VEC_LAST) != in_last) err_q <= 1'b1;
                        if (cnt_q == VEC_LAST) begin
                            cnt_q   <= '0;
                            state_q <= WAIT_RES;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    cnt_q <= '0;
                    if (s_axis_result_valid) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (res_fire) begin
                        if (cnt_q == VEC_LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef MV_SCHED_TIMEOUT_EN
            if (state_q == WAIT_RES || state_q == DRAIN) begin
                if (res_fire) begin
                    wd_q <= '0;
                end else if (wd_q == WD_LAST) begin
                    wd_q    <= '0;
                    err_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end else begin
                wd_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mv_job_scheduler.sv
// Bench for mv_job_scheduler: directed jobs, engine model and per-transfer scoreboard.
// Define MV_SCHED_TIMEOUT_EN to also exercise the result watchdog.
`timescale 1ns/1ps
module tb_mv_job_scheduler;

    localparam int DW = 32;
    localparam int MS = 2;
    localparam int NM = MS*MS;
    localparam int NB = NM+MS;

    logic            aclk       = 1'b0;
    logic            areset     = 1'b0;
    logic [1:0]      job_tvalid = '0;
    logic [1:0]      job_tlast  = '0;
    logic [2*DW-1:0] job_tdata  = '0;
    logic [1:0]      job_tready;
    logic            mat_valid, vec_valid;
    logic            mat_ready  = 1'b1;
    logic            vec_ready  = 1'b1;
    logic [DW-1:0]   mat_data, vec_data, out_data;
    logic            res_valid  = 1'b0;
    logic [DW-1:0]   res_data   = '0;
    logic            res_ready;
    logic            out_valid, out_last, out_dest;
    logic            out_ready  = 1'b1;
    logic            busy, perr;

    always #5 aclk = ~aclk;

    mv_job_scheduler #(
        .D_WIDTH(DW), .M_SIZE(MS), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_job_tvalid(job_tvalid),
        .s_axis_job_tdata(job_tdata),
        .s_axis_job_tlast(job_tlast),
        .s_axis_job_tready(job_tready),
        .m_axis_matrix_valid(mat_valid),
        .m_axis_matrix(mat_data),
        .m_axis_matrix_ready(mat_ready),
        .m_axis_vector_valid(vec_valid),
        .m_axis_vector(vec_data),
        .m_axis_vector_ready(vec_ready),
        .s_axis_result_valid(res_valid),
        .s_axis_result(res_data),
        .s_axis_result_ready(res_ready),
        .m_axis_out_valid(out_valid),
        .m_axis_out_data(out_data),
        .m_axis_out_last(out_last),
        .m_axis_out_dest(out_dest),
        .m_axis_out_ready(out_ready),
        .busy(busy),
        .protocol_err(perr)
    );

    typedef struct packed {
        logic [NB-1:0][DW-1:0] w;
        logic [NB-1:0]         l;
    } job_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          bad;
    } beat_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          dest;
        logic          last;
    } out_t;

    job_t          rq0[$], rq1[$], pend0[$], pend1[$];
    int            bidx0 = 0, bidx1 = 0;
    beat_t         exp_mat[$], exp_vec[$];
    out_t          exp_out[$], obs_out[$];
    logic [DW-1:0] obs_mat[$], obs_vec[$];
    logic [DW-1:0] em[$], ev[$], eq[$];
    int            checks = 0;
    int            errors = 0;
    bit            rnd_en = 0, silent = 0, vhold = 0, err_chk_en = 1;
    bit            err_model = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic job_t make_job(input int base, input int badpos);
        job_t j;
        for (int i = 0; i < NB; i++) begin
            j.w[i] = DW'(base + i);
            j.l[i] = (i == NB-1) || (i == badpos);
        end
        return j;
    endfunction

    task automatic add_job(input bit r, input job_t j);
        if (r) begin rq1.push_back(j); pend1.push_back(j); end
        else   begin rq0.push_back(j); pend0.push_back(j); end
    endtask

    // Model: the granted job's beats appear in order; results are M*v with dest tag.
    task automatic expect_grant(input bit g);
        job_t          j;
        logic [DW-1:0] s;
        j = g ? pend1.pop_front() : pend0.pop_front();
        for (int i = 0; i < NM; i++)
            exp_mat.push_back('{d: j.w[i], bad: j.l[i]});
        for (int i = 0; i < MS; i++)
            exp_vec.push_back('{d: j.w[NM+i], bad: j.l[NM+i] != (i == MS-1)});
        for (int k = 0; k < MS; k++) begin
            s = '0;
            for (int c = 0; c < MS; c++) s = s + j.w[k*MS+c] * j.w[NM+c];
            exp_out.push_back('{d: s, dest: g, last: (k == MS-1)});
        end
    endtask

    task automatic rst_on();
        @(posedge aclk); #2;
        areset = 1'b1;
        rq0.delete(); rq1.delete(); pend0.delete(); pend1.delete();
        bidx0 = 0; bidx1 = 0;
        exp_mat.delete(); exp_vec.delete(); exp_out.delete();
        obs_mat.delete(); obs_vec.delete(); obs_out.delete();
        em.delete(); ev.delete(); eq.delete();
        err_model = 0;
    endtask

    task automatic rst_off();
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (n < budget && !(rq0.size() == 0 && rq1.size() == 0 &&
               exp_mat.size() == 0 && exp_vec.size() == 0 &&
               exp_out.size() == 0 && !busy)) begin
            @(negedge aclk);
            n++;
        end
        chk(nm, n < budget, 1);
    endtask

    logic [1:0]    req_fire;
    logic          m_f, v_f, r_f;
    logic [DW-1:0] m_s, v_s;

    // Handshakes are sampled mid-cycle, where all inputs are stable.
    always @(negedge aclk) begin
        req_fire = job_tvalid & job_tready;
        m_f = mat_valid & mat_ready;
        v_f = vec_valid & vec_ready;
        r_f = res_valid & res_ready;
        m_s = mat_data;
        v_s = vec_data;
    end

    // Requester and engine stimulus, updated just after each rising edge.
    always @(posedge aclk) begin
        job_t          j;
        logic [DW-1:0] s;
        #1;
        if (!areset) begin
            if (req_fire[0]) begin
                bidx0++;
                if (bidx0 == NB) begin void'(rq0.pop_front()); bidx0 = 0; end
            end
            if (req_fire[1]) begin
                bidx1++;
                if (bidx1 == NB) begin void'(rq1.pop_front()); bidx1 = 0; end
            end
            if (m_f) em.push_back(m_s);
            if (v_f) ev.push_back(v_s);
            if (r_f) void'(eq.pop_front());
            if (em.size() == NM && ev.size() == MS) begin
                if (!silent) begin
                    for (int k = 0; k < MS; k++) begin
                        s = '0;
                        for (int c = 0; c < MS; c++) s = s + em[k*MS+c] * ev[c];
                        eq.push_back(s);
                    end
                end
                em.delete();
                ev.delete();
            end
        end
        if (rq0.size() > 0) begin
            j = rq0[0];
            job_tvalid[0]      = 1'b1;
            job_tdata[DW-1:0]  = j.w[bidx0];
            job_tlast[0]       = j.l[bidx0];
        end else begin
            job_tvalid[0]      = 1'b0;
            job_tdata[DW-1:0]  = '0;
            job_tlast[0]       = 1'b0;
        end
        if (rq1.size() > 0) begin
            j = rq1[0];
            job_tvalid[1]        = 1'b1;
            job_tdata[2*DW-1:DW] = j.w[bidx1];
            job_tlast[1]         = j.l[bidx1];
        end else begin
            job_tvalid[1]        = 1'b0;
            job_tdata[2*DW-1:DW] = '0;
            job_tlast[1]         = 1'b0;
        end
        res_valid = (eq.size() > 0);
        res_data  = (eq.size() > 0) ? eq[0] : '0;
        mat_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        vec_ready = vhold ? 1'b0 : (rnd_en ? 1'($urandom_range(0, 1)) : 1'b1);
        out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every transfer against the model, protocol_err every cycle.
    always @(negedge aclk) begin
        beat_t b;
        out_t  o;
        if (areset) begin
            chk("reset_outputs_zero",
                |{job_tready, mat_valid, mat_data, vec_valid, vec_data, res_ready,
                  out_valid, out_data, out_last, out_dest, busy, perr}, 0);
        end else begin
            if (err_chk_en) chk("protocol_err", perr, err_model);
            if (mat_valid && mat_ready) begin
                obs_mat.push_back(mat_data);
                if (exp_mat.size() == 0) chk("mat_extra_beat", 1, 0);
                else begin
                    b = exp_mat.pop_front();
                    chk("mat_data", mat_data, b.d);
                    if (b.bad) err_model = 1;
                end
            end
            if (vec_valid && vec_ready) begin
                obs_vec.push_back(vec_data);
                if (exp_vec.size() == 0) chk("vec_extra_beat", 1, 0);
                else begin
                    b = exp_vec.pop_front();
                    chk("vec_data", vec_data, b.d);
                    if (b.bad) err_model = 1;
                end
            end
            if (out_valid && out_ready) begin
                obs_out.push_back('{d: out_data, dest: out_dest, last: out_last});
                if (exp_out.size() == 0) chk("out_extra_beat", 1, 0);
                else begin
                    o = exp_out.pop_front();
                    chk("out_data", out_data, o.d);
                    chk("out_dest", out_dest, o.dest);
                    chk("out_last", out_last, o.last);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        #1 areset = 1'b1;

        // Scenario 1: single job from requester 0.
        rst_on();
        @(negedge aclk);
        chk("reset_busy", busy, 0);
        chk("reset_perr", perr, 0);
        add_job(0, make_job(1, -1));
        expect_grant(0);
        rst_off();
        wait_done("done_s1", 200);
        chk("s1_nmat", obs_mat.size(), 4);
        if (obs_mat.size() == 4) begin
            chk("s1_mat0", obs_mat[0], 1);
            chk("s1_mat3", obs_mat[3], 4);
        end
        chk("s1_nvec", obs_vec.size(), 2);
        if (obs_vec.size() == 2) begin
            chk("s1_vec0", obs_vec[0], 5);
            chk("s1_vec1", obs_vec[1], 6);
        end
        chk("s1_nout", obs_out.size(), 2);
        if (obs_out.size() == 2) begin
            chk("s1_out0", obs_out[0].d, 17);
            chk("s1_out1", obs_out[1].d, 39);
            chk("s1_dest", obs_out[0].dest, 0);
            chk("s1_last0", obs_out[0].last, 0);
            chk("s1_last1", obs_out[1].last, 1);
        end

        // Scenario 2: both requesters busy, strict alternation.
        rst_on();
        for (int k = 0; k < 3; k++) begin
            add_job(0, make_job(k*10 + 1, -1));
            add_job(1, make_job(100 + k*10 + 1, -1));
        end
        for (int k = 0; k < 6; k++) expect_grant(k[0]);
        rst_off();
        wait_done("done_s2", 800);
        chk("s2_nout", obs_out.size(), 12);
        if (obs_out.size() == 12) begin
            for (int k = 0; k < 6; k++) begin
                chk("s2_dest_order", obs_out[2*k].dest, k % 2);
                chk("s2_last", obs_out[2*k+1].last, 1);
            end
            chk("s2_out0", obs_out[0].d, 17);
            chk("s2_out2", obs_out[2].d, 21417);
            chk("s2_out3", obs_out[3].d, 21839);
        end

        // Scenario 3: random back-pressure on every engine/out port.
        rst_on();
        rnd_en = 1;
        add_job(0, make_job(1, -1));
        add_job(0, make_job(1, -1));
        expect_grant(0);
        expect_grant(0);
        rst_off();
        wait_done("done_s3", 1500);
        rnd_en = 0;
        chk("s3_nmat", obs_mat.size(), 8);
        chk("s3_nout", obs_out.size(), 4);
        if (obs_mat.size() == 8 && obs_vec.size() == 4 && obs_out.size() == 4) begin
            for (int k = 0; k < 8; k++) chk("s3_mat", obs_mat[k], (k % 4) + 1);
            for (int k = 0; k < 4; k++) chk("s3_vec", obs_vec[k], (k % 2) + 5);
            for (int k = 0; k < 4; k++) chk("s3_out", obs_out[k].d, (k % 2) ? 39 : 17);
        end

        // Scenario 4: early tlast on beat 3.
        rst_on();
        add_job(0, make_job(1, 2));
        expect_grant(0);
        rst_off();
        wait_done("done_s4", 200);
        chk("s4_perr", perr, 1);
        chk("s4_nmat", obs_mat.size(), 4);
        chk("s4_nvec", obs_vec.size(), 2);
        chk("s4_nout", obs_out.size(), 2);

        // Scenario 5: reset while loading the vector.
        rst_on();
        vhold = 1;
        add_job(0, make_job(1, -1));
        expect_grant(0);
        rst_off();
        n = 0;
        while (n < 50 && !vec_valid) begin @(negedge aclk); n++; end
        chk("s5_reach_load_vec", vec_valid, 1);
        chk("s5_busy_loading", busy, 1);
        rst_on();
        vhold = 0;
        @(negedge aclk);
        chk("s5_busy_in_reset", busy, 0);
        chk("s5_vec_valid_in_reset", vec_valid, 0);
        add_job(1, make_job(101, -1));
        add_job(0, make_job(11, -1));
        expect_grant(0);
        expect_grant(1);
        rst_off();
        wait_done("done_s5", 300);
        chk("s5_nout", obs_out.size(), 4);
        if (obs_out.size() == 4) begin
            chk("s5_first_dest", obs_out[0].dest, 0);
            chk("s5_first_data", obs_out[0].d, 357);
            chk("s5_second_data", obs_out[1].d, 419);
            chk("s5_third_dest", obs_out[2].dest, 1);
        end

`ifdef MV_SCHED_TIMEOUT_EN
        // Scenario 6: engine never answers, watchdog releases the scheduler.
        rst_on();
        silent = 1;
        err_chk_en = 0;
        add_job(0, make_job(1, -1));
        expect_grant(0);
        rst_off();
        n = 0;
        while (n < 100 && exp_vec.size() != 0) begin @(negedge aclk); n++; end
        chk("s6_vec_done", exp_vec.size(), 0);
        n = 0;
        while (n < 40 && !(!busy && perr)) begin @(negedge aclk); n++; end
        chk("s6_latency_le18", n <= 18, 1);
        chk("s6_perr", perr, 1);
        chk("s6_busy", busy, 0);
        chk("s6_no_out", obs_out.size(), 0);
        rst_on();
        silent = 0;
        err_chk_en = 1;
        rst_off();
`endif

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
